// File: rtl/preg_free_list_pkg.sv
// rtl/preg_free_list_pkg.sv - shared widths and constants for the physical register free list
package preg_free_list_pkg;
  localparam int NUM_PREG = 64;
  localparam int PREG_W   = 6;
  localparam int FL_DEPTH = 32;
  localparam int CNT_W    = 6;
  localparam int PTR_W    = 5;

  // p0 is the hard-wired x0 mapping and never re-enters the free list
  localparam logic [PREG_W-1:0] X0_PREG = '0;
endpackage

// File: rtl/preg_free_list_lsb_pick64.sv
// rtl/preg_free_list_lsb_pick64.sv - lowest-set-bit encoder over a 64-bit vector
module lsb_pick64
  import preg_free_list_pkg::*;
(
  input  logic [NUM_PREG-1:0] vec_i,
  output logic                found_o,
  output logic [PREG_W-1:0]   idx_o
);

  always_comb begin
    found_o = |vec_i;
    idx_o   = '0;
    // Scan high to low so the lowest set bit is the last one written
    for (int i = NUM_PREG - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = PREG_W'(i);
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - circular free list of physical registers with retire-mask drain
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                alloc_req,
  output logic                alloc_valid,
  output logic [PREG_W-1:0]   alloc_preg,
  output logic                stall,
  input  logic [NUM_PREG-1:0] retire_mask,
  output logic                free_busy,
  output logic [CNT_W-1:0]    free_count,
  output logic                err_double_free,
  output logic                err_overflow
);

  logic [PREG_W-1:0]   fl_q [FL_DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  logic [NUM_PREG-1:0] pend_q, pend_d;
  logic                err_dfree_q, err_ovf_q;

  logic                drain_found;
  logic [PREG_W-1:0]   drain_idx;
  logic [NUM_PREG-1:0] drain_bit;
  logic [NUM_PREG-1:0] retire_clean;
  logic                pop, push, full, ovf_ev, dfree_ev;

  lsb_pick64 u_pick (
    .vec_i   (pend_q),
    .found_o (drain_found),
    .idx_o   (drain_idx)
  );

  assign alloc_valid     = (count_q != '0);
  assign stall           = (count_q == '0);
  assign alloc_preg      = fl_q[head_q];
  assign free_busy       = |pend_q;
  assign free_count      = count_q;
  assign err_double_free = err_dfree_q;
  assign err_overflow    = err_ovf_q;

  always_comb begin
    retire_clean          = retire_mask;
    retire_clean[X0_PREG] = 1'b0;
    drain_bit             = drain_found ? (NUM_PREG'(1) << drain_idx) : '0;
    pop                   = alloc_req && alloc_valid;
    full                  = (count_q == CNT_W'(FL_DEPTH));
    // A full list can still accept a push when the head leaves in the same cycle
    push                  = drain_found && (!full || pop);
    ovf_ev                = drain_found && full && !pop;
    dfree_ev              = |(retire_clean & pend_q);
    pend_d                = (pend_q & ~drain_bit) | retire_clean;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PREG_W'(FL_DEPTH + i);
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= CNT_W'(FL_DEPTH);
      pend_q      <= '0;
      err_dfree_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (pop) head_q <= head_q + PTR_W'(1);
      if (push) begin
        fl_q[tail_q] <= drain_idx;
        tail_q       <= tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (dfree_ev) err_dfree_q <= 1'b1;
      if (ovf_ev)   err_ovf_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// tb/tb_preg_free_list.sv - randomized and directed bench against a queue-based free list model
module tb_preg_free_list;
  logic        clk = 1'b0;
  logic        rstn;
  logic        alloc_req;
  logic        alloc_valid;
  logic [5:0]  alloc_preg;
  logic        stall;
  logic [63:0] retire_mask;
  logic        free_busy;
  logic [5:0]  free_count;
  logic        err_double_free;
  logic        err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_q[$];
  logic [63:0] m_pend;
  bit          m_dfree, m_ovf;

  always #5 clk = ~clk;

  preg_free_list dut (
    .clk             (clk),
    .rstn            (rstn),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_preg      (alloc_preg),
    .stall           (stall),
    .retire_mask     (retire_mask),
    .free_busy       (free_busy),
    .free_count      (free_count),
    .err_double_free (err_double_free),
    .err_overflow    (err_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q = {};
    for (int i = 32; i < 64; i++) m_q.push_back(i);
    m_pend  = '0;
    m_dfree = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit req, input logic [63:0] mask);
    logic [63:0] clean;
    int lo;
    clean = mask;
    clean[0] = 1'b0;
    if ((clean & m_pend) != 0) m_dfree = 1;
    lo = -1;
    for (int i = 0; i < 64; i++) if (lo < 0 && m_pend[i]) lo = i;
    if (req && m_q.size() > 0) void'(m_q.pop_front());
    if (lo >= 0) begin
      if (m_q.size() < 32) m_q.push_back(lo);
      else m_ovf = 1;
      m_pend[lo] = 1'b0;
    end
    m_pend = m_pend | clean;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, alloc_valid, m_q.size() != 0);
    check({tag, ".stall"}, stall, m_q.size() == 0);
    check({tag, ".count"}, free_count, m_q.size());
    check({tag, ".busy"}, free_busy, m_pend != 0);
    check({tag, ".dfree"}, err_double_free, m_dfree);
    check({tag, ".ovf"}, err_overflow, m_ovf);
    if (m_q.size() != 0) check({tag, ".preg"}, alloc_preg, m_q[0]);
  endtask

  task automatic cycle(input bit req, input logic [63:0] mask, input string tag);
    alloc_req   = req;
    retire_mask = mask;
    @(negedge clk);
    compare_all(tag);
    @(posedge clk);
    model_step(req, mask);
    #1;
  endtask

  task automatic do_reset();
    alloc_req   = 1'b0;
    retire_mask = '0;
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    model_step(0, '0);
    #1;
  endtask

  initial begin
    logic [63:0] m;
    rstn        = 1'b0;
    alloc_req   = 1'b0;
    retire_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    check("reset.count", free_count, 32);
    check("reset.preg", alloc_preg, 32);
    check("reset.busy", free_busy, 0);

    for (int i = 0; i < 32; i++) begin
      check("seq.preg", alloc_preg, 32 + i);
      cycle(1, '0, "seq");
    end
    check("empty.stall", stall, 1);
    check("empty.valid", alloc_valid, 0);
    check("empty.count", free_count, 0);
    cycle(1, '0, "empty_req");

    cycle(0, 64'h1 << 40, "r40");
    check("r40.busy", free_busy, 1);
    check("r40.novalid", alloc_valid, 0);
    cycle(0, '0, "r40b");
    check("r40.valid", alloc_valid, 1);
    check("r40.preg", alloc_preg, 40);
    check("r40.count", free_count, 1);
    cycle(1, '0, "pop40");

    cycle(0, (64'h1 << 5) | (64'h1 << 7) | (64'h1 << 9), "r579");
    for (int i = 0; i < 3; i++) cycle(0, '0, "drain579");
    check("r579.count", free_count, 3);
    check("r579.busy", free_busy, 0);
    check("r579.head", alloc_preg, 5);

    cycle(0, 64'h1, "x0");
    check("x0.busy", free_busy, 0);
    check("x0.count", free_count, 3);

    cycle(0, (64'h1 << 1) | (64'h1 << 2) | (64'h1 << 12), "r12a");
    cycle(0, 64'h1 << 12, "r12b");
    for (int i = 0; i < 4; i++) cycle(0, '0, "drain12");
    check("r12.dfree", err_double_free, 1);
    check("r12.count", free_count, 6);

    do_reset();
    cycle(0, 64'h1 << 3, "full3");
    cycle(1, '0, "fullpop");
    check("full.count", free_count, 32);
    check("full.noovf", err_overflow, 0);
    cycle(0, 64'h1 << 4, "full4");
    cycle(0, '0, "fullpush");
    check("full.ovf", err_overflow, 1);
    check("full.count2", free_count, 32);
    cycle(1, 64'h1 << 6, "pre_rst");
    alloc_req = 1'b1;
    retire_mask = 64'h1 << 8;
    #1;
    rstn = 1'b0;
    #1;
    check("midrst.count", free_count, 32);
    check("midrst.preg", alloc_preg, 32);
    check("midrst.busy", free_busy, 0);
    check("midrst.ovf", err_overflow, 0);
    do_reset();

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      m = '0;
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) m[$urandom_range(0, 63)] = 1'b1;
      cycle($urandom_range(0, 2) != 0, m, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
